fs_accel_config_loader: RTL and testbench

FS_ACCEL_CONFIG_LOADER -- requirements
Module: fs_accel_config_loader

---
 rtl/fs_accel_config_loader_if.sv | 21 ++
 rtl/fs_accel_config_loader.sv | 147 ++++++++++++++
 tb/tb_fs_accel_config_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fs_accel_config_loader_if.sv
// Loader-side bus bundle: descriptor memory read port plus accelerator config write port.
// The loader sits on the master modport; the memory/config-register side uses slave.
interface fs_accel_config_loader_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] config_data;
    logic [4:0]  config_sel;
    logic        config_wen;

    modport master (
        output mem_valid, mem_addr, config_data, config_sel, config_wen,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, config_data, config_sel, config_wen,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/fs_accel_config_loader.sv
// Walks one layer descriptor in memory and replays it as a sequence of config register
// writes: 16 header words, then (select, multiplier, shift) triples per quant channel.
module fs_accel_config_loader #(
    parameter int MAX_CH = 36
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [31:0]                desc_base_addr,
    input  logic [5:0]                 num_quant_ch,
    fs_accel_config_loader_if.master   bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [3:0] {
        IDLE,
        HDR_FETCH,
        HDR_WR,
        QSEL_WR,
        QMUL_FETCH,
        QMUL_WR,
        QSH_FETCH,
        QSH_WR,
        DONE
    } state_t;

    localparam logic [4:0] SEL_QSEL = 5'd12;
    localparam logic [4:0] SEL_QMUL = 5'd13;
    localparam logic [4:0] SEL_QSH  = 5'd14;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  hdr_idx_q;
    logic [5:0]  ch_idx_q;
    logic [5:0]  n_q;
    logic        err_q;

    logic        fetching;
    logic        mem_hs;
    logic        start_ok;
    logic        start_bad;
    logic        last_hdr;
    logic        last_ch;
    logic [4:0]  hdr_sel;

    assign fetching  = (state_q == HDR_FETCH) || (state_q == QMUL_FETCH) || (state_q == QSH_FETCH);
    // mem_ready only counts while we are actually requesting
    assign mem_hs    = fetching && bus.mem_ready;
    assign start_ok  = (state_q == IDLE) && start && (num_quant_ch <= 6'(MAX_CH));
    assign start_bad = (state_q == IDLE) && start && (num_quant_ch >  6'(MAX_CH));
    assign last_hdr  = (hdr_idx_q == 4'd15);
    assign last_ch   = (ch_idx_q == n_q - 6'd1);
    // header words 12..15 land on sel 15..18, leaving 12..14 for the quant triple
    assign hdr_sel   = (hdr_idx_q < 4'd12) ? {1'b0, hdr_idx_q} : ({1'b0, hdr_idx_q} + 5'd3);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start_ok) state_d = HDR_FETCH;
            HDR_FETCH:  if (bus.mem_ready) state_d = HDR_WR;
            HDR_WR: begin
                if (!last_hdr)        state_d = HDR_FETCH;
                else if (n_q != 6'd0) state_d = QSEL_WR;
                else                  state_d = DONE;
            end
            QSEL_WR:    state_d = QMUL_FETCH;
            QMUL_FETCH: if (bus.mem_ready) state_d = QMUL_WR;
            QMUL_WR:    state_d = QSH_FETCH;
            QSH_FETCH:  if (bus.mem_ready) state_d = QSH_WR;
            QSH_WR:     state_d = last_ch ? DONE : QSEL_WR;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // address, capture and sequencing counters
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            hdr_idx_q <= '0;
            ch_idx_q  <= '0;
            n_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                addr_q    <= {desc_base_addr[31:2], 2'b00};
                n_q       <= num_quant_ch;
                hdr_idx_q <= '0;
                ch_idx_q  <= '0;
            end
            if (mem_hs) begin
                data_q <= bus.mem_rdata;
                addr_q <= addr_q + 32'd4;
            end
            if (state_q == HDR_WR) hdr_idx_q <= hdr_idx_q + 4'd1;
            if (state_q == QSH_WR) ch_idx_q  <= ch_idx_q + 6'd1;
        end
    end

    // outputs
    always_comb begin
        bus.mem_valid   = fetching;
        bus.mem_addr    = addr_q;
        bus.config_wen  = 1'b0;
        bus.config_sel  = '0;
        bus.config_data = '0;
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        err             = err_q;
        case (state_q)
            HDR_WR: begin
                bus.config_wen  = 1'b1;
                bus.config_sel  = hdr_sel;
                bus.config_data = data_q;
            end
            QSEL_WR: begin
                bus.config_wen  = 1'b1;
                bus.config_sel  = SEL_QSEL;
                bus.config_data = {26'd0, ch_idx_q};
            end
            QMUL_WR: begin
                bus.config_wen  = 1'b1;
                bus.config_sel  = SEL_QMUL;
                bus.config_data = data_q;
            end
            QSH_WR: begin
                bus.config_wen  = 1'b1;
                bus.config_sel  = SEL_QSH;
                bus.config_data = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fs_accel_config_loader.sv
// Scoreboard bench: expected config writes and fetch addresses are queued at start and
// retired as the loader produces them; a small memory model answers fetches.
module tb_fs_accel_config_loader;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] desc_base_addr;
    logic [5:0]  num_quant_ch;
    logic        busy, done, err;

    fs_accel_config_loader_if mif();

    fs_accel_config_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .desc_base_addr (desc_base_addr),
        .num_quant_ch   (num_quant_ch),
        .bus            (mif.master),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wr_t         exp_wr[$];
    logic [31:0] exp_addr[$];

    bit          stall_en = 1'b0;
    bit          err_ok   = 1'b0;
    bit          hs_seen  = 1'b0;
    int          wait_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    function automatic logic [4:0] hsel(input int k);
        return (k < 12) ? 5'(k) : 5'(k + 3);
    endfunction

    assign mif.mem_rdata = memf(mif.mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        logic [31:0] a;
        wr_t w;
        a = {base[31:2], 2'b00};
        for (int k = 0; k < 16; k++) begin
            w.sel = hsel(k); w.data = memf(a + 32'(4*k));
            exp_wr.push_back(w);
            exp_addr.push_back(a + 32'(4*k));
        end
        for (int c = 0; c < n; c++) begin
            w.sel = 5'd12; w.data = 32'(c);
            exp_wr.push_back(w);
            w.sel = 5'd13; w.data = memf(a + 32'(64 + 8*c));
            exp_wr.push_back(w);
            exp_addr.push_back(a + 32'(64 + 8*c));
            w.sel = 5'd14; w.data = memf(a + 32'(68 + 8*c));
            exp_wr.push_back(w);
            exp_addr.push_back(a + 32'(68 + 8*c));
        end
    endtask

    // memory ready: always 1, or random 0-5 cycle stall before each accepted fetch
    always @(posedge clk) begin
        #1;
        if (!stall_en) mif.mem_ready = 1'b1;
        else begin
            if (hs_seen) wait_cnt = $urandom_range(0, 5);
            if (wait_cnt > 0) begin
                mif.mem_ready = 1'b0;
                wait_cnt--;
            end else mif.mem_ready = 1'b1;
        end
    end

    // monitor / scoreboard retire
    always @(negedge clk) begin
        wr_t w;
        logic [31:0] ea;
        if (mif.config_wen || mif.mem_valid)
            chk("wen_valid_excl", 32'(mif.config_wen && mif.mem_valid), 0);
        if (mif.config_wen) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'(exp_wr.size()), 1);
            else begin
                w = exp_wr.pop_front();
                chk("wr_sel", 32'(mif.config_sel), 32'(w.sel));
                chk("wr_data", mif.config_data, w.data);
            end
        end
        if (mif.mem_valid && mif.mem_ready) begin
            if (exp_addr.size() == 0) chk("fetch_unexpected", 32'(exp_addr.size()), 1);
            else begin
                ea = exp_addr.pop_front();
                chk("fetch_addr", mif.mem_addr, ea);
            end
        end
        if (mif.mem_valid && prev_stall) chk("addr_hold", mif.mem_addr, prev_addr);
        if (err && !err_ok) chk("err_spurious", 32'(err), 0);
        prev_stall = mif.mem_valid && !mif.mem_ready && !reset;
        prev_addr  = mif.mem_addr;
        hs_seen    = mif.mem_valid && mif.mem_ready;
    end

    task automatic run_load(input logic [31:0] base, input int n, input bit check_lat,
                            input bit extra_starts);
        int k;
        push_exp(base, n);
        @(posedge clk); #1;
        start = 1'b1; desc_base_addr = base; num_quant_ch = 6'(n);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_running", 32'(busy), 1);
            if (extra_starts) begin
                start = (k == 4 || k == 11 || k == 25);
                desc_base_addr = 32'h5550;
                num_quant_ch   = (k == 11) ? 6'd40 : 6'd5;
            end
            if (done) break;
            if (k >= 3000) begin
                chk("done_timeout", 32'(done), 1);
                break;
            end
        end
        start = 1'b0;
        if (check_lat) chk("done_cycle", 32'(k), 32'(33 + 5*n));
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("wr_left", 32'(exp_wr.size()), 0);
        chk("addr_left", 32'(exp_addr.size()), 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; desc_base_addr = '0; num_quant_ch = '0;
        mif.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid", 32'(mif.mem_valid), 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_wen", 32'(mif.config_wen), 0);
        chk("rst_sel", 32'(mif.config_sel), 0);
        chk("rst_data", mif.config_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);

        // reset wins over a simultaneous start
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; desc_base_addr = 32'h1000; num_quant_ch = 6'd2;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 0);

        run_load(32'h1000, 3, 1'b1, 1'b0);
        run_load(32'h1000, 0, 1'b1, 1'b0);
        run_load(32'h4000, 36, 1'b1, 1'b0);

        // over-limit channel count
        err_ok = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; desc_base_addr = 32'h1000; num_quant_ch = 6'd37;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(err), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_valid", 32'(mif.mem_valid), 0);
        @(negedge clk);
        chk("err_clear", 32'(err), 0);
        chk("err_busy2", 32'(busy), 0);
        err_ok = 1'b0;

        stall_en = 1'b1;
        run_load(32'h1000, 3, 1'b0, 1'b0);
        stall_en = 1'b0;

        // abort during channel-1 multiplier fetch
        push_exp(32'h2000, 3);
        repeat (5) void'(exp_wr.pop_back());
        repeat (3) void'(exp_addr.pop_back());
        @(posedge clk); #1;
        start = 1'b1; desc_base_addr = 32'h2000; num_quant_ch = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (mif.config_wen && mif.config_sel == 5'd12 && mif.config_data == 32'd1) break;
            if (k >= 500) begin
                chk("qsel1_timeout", 32'(mif.config_sel), 12);
                break;
            end
        end
        @(negedge clk);
        chk("abort_in_fetch", 32'(mif.mem_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(mif.mem_valid), 0);
        chk("abort_wen", 32'(mif.config_wen), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_wr_left", 32'(exp_wr.size()), 0);
        chk("abort_addr_left", 32'(exp_addr.size()), 0);
        run_load(32'h3000, 2, 1'b1, 1'b0);

        // misaligned base and starts while busy
        run_load(32'h1003, 2, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
